// File: rtl/tristate_bus_arbiter_pkg.sv
// tristate_bus_arbiter_pkg: shared FSM encodings and width/constant helpers
// for the tristate bus arbiter and its round-robin picker.
package tristate_bus_arbiter_pkg;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] TURN  = 2'd2;
  localparam int ZMAX = 256;
  function automatic logic [ZMAX-1:0] all_z();
    return {ZMAX{1'bz}};
  endfunction
  // Index width that never collapses to zero bits
  function automatic int clog2w(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction
endpackage

// File: rtl/tristate_bus_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester at or
// after ptr_i, wrapping modulo NUM_CH.
module rr_arbiter
  import tristate_bus_arbiter_pkg::*;
#(
  parameter int NUM_CH = 4,
  localparam int IW = clog2w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IW-1:0]     ptr_i,
  output logic [NUM_CH-1:0] onehot_o,
  output logic [IW-1:0]     idx_o,
  output logic              valid_o
);
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    // Scan from the farthest offset down so the nearest requester wins last
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req_i[(int'(ptr_i) + i) % NUM_CH]) begin
        idx_o   = IW'((int'(ptr_i) + i) % NUM_CH);
        valid_o = 1'b1;
      end
    end
    onehot_o        = '0;
    onehot_o[idx_o] = valid_o;
  end
endmodule

// File: rtl/tristate_bus_arbiter.sv
// tristate_bus_arbiter: round-robin owner of a shared tristate bus with
// registered grant, bounded hold time and a high-Z turnaround gap.
module tristate_bus_arbiter
  import tristate_bus_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 4,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 4,
  localparam int IW = clog2w(NUM_CH),
  localparam int HW = $clog2(MAX_HOLD + 1),
  localparam int TW = clog2w(TURNAROUND + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            req,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
  output logic [NUM_CH-1:0]            gnt,
  output logic [DATA_WIDTH-1:0]        bus_data,
  output logic [IW-1:0]                bus_owner,
  output logic                         bus_busy
);
  logic [1:0]        state_q, state_d;
  logic [NUM_CH-1:0] gnt_q, gnt_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [TW-1:0]     turn_q, turn_d;
  logic [NUM_CH-1:0] win_oh;
  logic [IW-1:0]     win_idx;
  logic              win_valid;
  logic              in_drive, keep, others, release_now, go;
  logic [IW-1:0]     ptr_next;
  assign in_drive    = state_q == DRIVE;
  assign keep        = |(req & gnt_q);
  assign others      = |(req & ~gnt_q);
  assign release_now = !keep || (hold_q == HW'(MAX_HOLD) && others);
  assign ptr_next    = (owner_q == IW'(NUM_CH - 1)) ? '0 : owner_q + 1'b1;
  // Same-edge re-arbitration out of DRIVE skips the releasing owner
  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
    .req_i    (in_drive ? req & ~gnt_q : req),
    .ptr_i    (in_drive ? ptr_next : ptr_q),
    .onehot_o (win_oh),
    .idx_o    (win_idx),
    .valid_o  (win_valid)
  );
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    go      = 1'b0;
    case (state_q)
      IDLE: go = 1'b1;
      DRIVE: begin
        if (release_now) begin
          ptr_d   = ptr_next;
          gnt_d   = '0;
          owner_d = '0;
          hold_d  = '0;
          state_d = TURN;
          turn_d  = TW'(TURNAROUND);
          go      = TURNAROUND == 0;
        end else begin
          hold_d = (hold_q == HW'(MAX_HOLD)) ? hold_q : hold_q + 1'b1;
        end
      end
      TURN: begin
        go     = turn_q <= TW'(1);
        turn_d = go ? '0 : turn_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (go) begin
      state_d = win_valid ? DRIVE : IDLE;
      gnt_d   = win_oh;
      owner_d = win_idx;
      hold_d  = HW'(win_valid);
      turn_d  = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      turn_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
    end
  end
  assign gnt       = gnt_q;
  assign bus_owner = owner_q;
  assign bus_busy  = state_q != IDLE;
  assign bus_data  = in_drive ? data_in[owner_q*DATA_WIDTH +: DATA_WIDTH] : {DATA_WIDTH{1'bz}};
endmodule

// File: doc/tristate_bus_arbiter.md
Name: tristate_bus_arbiter

Overview:
- Multi-channel, registered successor to the single-enable tristate driver.
- NUM_CH sources share one DATA_WIDTH-bit tristate data bus.
- Round-robin arbitration, registered grant and output enable, bounded hold time, and a high-Z turnaround gap between owners.
- Sits between the datapath sources (ALU, memory, instruction register, I/O) and the shared CPU data bus.

Parameters:
- DATA_WIDTH, 8: bus and per-channel data width.
- NUM_CH, 4: number of requesting channels, 2..16.
- TURNAROUND, 1: high-Z cycles inserted between two owners, 0..7.
- MAX_HOLD, 4: maximum consecutive drive cycles while another channel is requesting, 1..255.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_CH  per-channel bus request, level-sensitive.
- data_in  in  NUM_CH*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- gnt  out  NUM_CH  one-hot grant, registered.
- bus_data  out  DATA_WIDTH  shared bus: owner data when driving, all-Z otherwise.
- bus_owner  out  max(1,$clog2(NUM_CH))  index of the current owner, 0 when idle.
- bus_busy  out  1  high while in DRIVE or TURN.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; gnt=0; bus_owner=0; bus_busy=0; bus_data=all-Z.
  - RR pointer=0; hold counter=0; turn counter=0.
  - Reset mid-DRIVE releases the bus (Z) immediately, without waiting for a clock edge.
- Bus drive:
  - bus_data = data_in slice of bus_owner when in DRIVE, else all-Z.
  - Output enable is registered state; data passes combinationally from the owner's data_in.
- States: IDLE, DRIVE, TURN.
- IDLE:
  - If req != 0, pick the first requester at or after the RR pointer, wrapping modulo NUM_CH.
  - Next edge: gnt=onehot(winner), bus_owner=winner, state=DRIVE, hold=1.
  - Latency req→gnt and req→bus driven: exactly 1 clock.
  - If req == 0, remain in IDLE.
- DRIVE:
  - Owner keeps the bus while req[owner]=1; the hold counter increments each cycle, saturating at MAX_HOLD.
  - Release occurs when either condition holds:
    - (a) req[owner]=0; or
    - (b) hold==MAX_HOLD and any other req bit is set.
  - A lone requester is never preempted.
  - On release:
    - gnt=0; bus Z from the next edge; RR pointer=(owner+1) mod NUM_CH.
    - Go to TURN with turn counter=TURNAROUND.
    - If TURNAROUND==0, arbitrate in the same edge instead: go directly to DRIVE for the new winner (owner excluded when released by (b)), or to IDLE if no winner.
- TURN:
  - bus_data Z; gnt=0; bus_busy=1; decrement the counter each cycle.
  - When the counter reaches 1, arbitrate as in IDLE on that edge, going to DRIVE or IDLE.
  - Requests arriving during TURN are held and considered at that point.
- Gap between owners is exactly TURNAROUND cycles of Z. Two channels never drive in the same cycle.
- Simultaneous requests: the RR pointer decides. After reset, channel 0 wins over all others.
- req[owner] dropping at the MAX_HOLD edge is treated as release (a); the pointer update is identical in both cases.
- Grant is not revoked for an input glitch on a non-owner channel.
- Width rules:
  - Hold counter is $clog2(MAX_HOLD+1) bits.
  - Turn counter is $clog2(TURNAROUND+1) bits, minimum 1.
  - Pointer arithmetic wraps cleanly for non-power-of-two NUM_CH.

Decomposition:
- Shared package holds:
  - State encoding localparams: IDLE=2'd0, DRIVE=2'd1, TURN=2'd2.
  - An all-Z constant helper function.
  - The clog2 width helper.
- One natural sub-module, rr_arbiter: combinational round-robin pick from req and pointer, producing a one-hot winner, its index, and a valid flag.
- The FSM, counters and tristate drive stay in the top level.

Test Plan:
- Reset: rst_n=0 with req=4'b1111 → bus_data=8'hZZ, gnt=0, bus_busy=0. Release reset; req[2]=1, data_in[2]=8'h55 → one clock later gnt=4'b0100, bus_data=8'h55, bus_owner=2.
- Turnaround: ch2 drops req while req[0]=1, data_in[0]=8'hAA → exactly 1 cycle of 8'hZZ, then gnt=4'b0001, bus_data=8'hAA.
- Round-robin: all four requesting from reset, each held → grant order 0,1,2,3,0. Each tenure is 4 cycles (MAX_HOLD), separated by one Z cycle.
- No preemption: req=4'b1000 held for 20 cycles → gnt stays 4'b1000 and bus_data tracks data_in[3] every cycle.
- Async reset mid-drive: rst_n pulsed low between clock edges while ch1 drives 8'h3C → bus_data=8'hZZ and gnt=0 immediately. After reset, ch0 wins a 0/1 tie.
- TURNAROUND=0 instance: owner releases with another requester pending → the next owner drives on the following cycle with no Z gap. A checker asserts at most one gnt bit set in every cycle.
